// File: rtl/program_loader.sv
// Host-link program loader: unpacks a length-prefixed byte stream into 16-bit
// instruction words, writes them to instruction memory and stalls the cores meanwhile.
module program_loader #(
   parameter int PC_WIDTH  = 12,
   parameter int MAX_WORDS = 4096
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                in_valid,
   input  logic [7:0]          in_data,
   output logic                in_ready,
   output logic                imem_we,
   output logic [PC_WIDTH-1:0] imem_addr,
   output logic [15:0]         imem_wdata,
   output logic                hold_core,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [PC_WIDTH:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_INS_HI = 3'd3,
      S_INS_LO = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   localparam logic [16:0]     MAX_LEN  = 17'(MAX_WORDS);
   localparam logic [PC_WIDTH:0] WORD_ONE = {{PC_WIDTH{1'b0}}, 1'b1};

   // Opcode 4'hF is the only undefined encoding.
   function automatic logic opcode_illegal(input logic [3:0] opcode);
      return (opcode == 4'hF);
   endfunction

   state_t                state_q, state_d;
   logic                  in_ready_q, in_ready_d;
   logic [7:0]            len_hi_q, len_hi_d;
   logic [PC_WIDTH:0]     n_q, n_d;
   logic [7:0]            hi_q, hi_d;
   logic                  we_q, we_d;
   logic [PC_WIDTH-1:0]   addr_q, addr_d;
   logic [15:0]           wdata_q, wdata_d;
   logic                  busy_q, busy_d;
   logic                  hold_q, hold_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic [PC_WIDTH:0]     words_q, words_d;
   logic                  hs_s;
   logic [16:0]           len_s;
   logic [PC_WIDTH:0]     words_inc_s;

   assign hs_s        = in_valid && in_ready_q;
   assign len_s       = {1'b0, len_hi_q, in_data};
   assign words_inc_s = words_q + WORD_ONE;

   // Next-state and next-output computation.
   always_comb begin
      state_d  = state_q;
      len_hi_d = len_hi_q;
      n_d      = n_q;
      hi_d     = hi_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      busy_d   = busy_q;
      hold_d   = hold_q;
      done_d   = 1'b0;
      error_d  = error_q;
      words_d  = words_q;

      // Release the cores one cycle after the final write.
      if (done_q) begin
         busy_d = 1'b0;
         hold_d = 1'b0;
      end else begin
         busy_d = busy_q;
      end

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start && !busy_q) begin
               state_d = S_LEN_HI;
               busy_d  = 1'b1;
               hold_d  = 1'b1;
               error_d = 1'b0;
               words_d = '0;
            end else begin
               state_d = state_q;
            end
         end
         S_LEN_HI: begin
            if (hs_s) begin
               len_hi_d = in_data;
               state_d  = S_LEN_LO;
            end else begin
               state_d = state_q;
            end
         end
         S_LEN_LO: begin
            if (hs_s) begin
               if ((len_s == 17'd0) || (len_s > MAX_LEN)) begin
                  state_d = S_ERR;
                  error_d = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  n_d     = len_s[PC_WIDTH:0];
                  state_d = S_INS_HI;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_INS_HI: begin
            if (hs_s) begin
               hi_d    = in_data;
               state_d = S_INS_LO;
            end else begin
               state_d = state_q;
            end
         end
         S_INS_LO: begin
            if (hs_s) begin
               if (opcode_illegal(hi_q[7:4])) begin
                  state_d = S_ERR;
                  error_d = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  we_d    = 1'b1;
                  addr_d  = words_q[PC_WIDTH-1:0];
                  wdata_d = {hi_q, in_data};
                  words_d = words_inc_s;
                  if (words_inc_s == n_q) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_INS_HI;
                  end
               end
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                   (state_d == S_INS_HI) || (state_d == S_INS_LO);
   end

   // State and registered-output update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         in_ready_q <= 1'b0;
         len_hi_q   <= 8'h00;
         n_q        <= '0;
         hi_q       <= 8'h00;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 16'h0000;
         busy_q     <= 1'b0;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         words_q    <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         len_hi_q   <= len_hi_d;
         n_q        <= n_d;
         hi_q       <= hi_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         busy_q     <= busy_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         error_q    <= error_d;
         words_q    <= words_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign hold_core    = hold_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table vectors, hand-written corner
// sequences and randomized loads checked against a stream-level reference model.
module tb_program_loader;

   logic        clk, rst_n, start, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, imem_we, hold_core, busy, done, error;
   logic [11:0] imem_addr;
   logic [15:0] imem_wdata;
   logic [12:0] words_loaded;

   program_loader #(.PC_WIDTH(12), .MAX_WORDS(4096)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .hold_core(hold_core), .busy(busy), .done(done), .error(error),
      .words_loaded(words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int hs_cnt = 0;
   int hs_at_edge = 0;
   int done_cnt = 0;
   int done_nowe = 0;
   int stalls = 0;
   logic [31:0] wr_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Count handshakes per load so each write can be tied to its low byte.
   always @(posedge clk) begin
      if (in_valid && in_ready) begin
         hs_cnt     <= hs_cnt + 1;
         hs_at_edge <= hs_cnt + 1;
      end else begin
         hs_at_edge <= 0;
      end
   end

   always @(negedge clk) begin
      if (imem_we) begin
         check("we_latency", hs_at_edge, 2 * wr_q.size() + 4);
         wr_q.push_back({4'h0, imem_addr, imem_wdata});
      end
      if (done) begin
         done_cnt++;
         if (!imem_we) done_nowe++;
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_imem_we"}, imem_we, 0);
      check({tag, "_imem_addr"}, imem_addr, 0);
      check({tag, "_imem_wdata"}, imem_wdata, 0);
      check({tag, "_hold_core"}, hold_core, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_words_loaded"}, words_loaded, 0);
   endtask

   // Offer one byte (after optional idle gap) until accepted or the bound expires.
   task automatic send_byte(input logic [7:0] b, input int gap_max, input bit noise);
      int  g;
      bit  acc;
      g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      for (int i = 0; i < g; i++) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      acc      = 1'b0;
      for (int t = 0; t < 64 && !acc; t++) begin
         acc = in_ready;
         if (!acc) stalls++;
         start = noise && ($urandom_range(3, 0) == 0);
         @(negedge clk);
         start = 1'b0;
      end
      if (!acc) begin
         n_cmp++;
         n_fail++;
         $display("FAIL handshake_timeout: byte 0x%02h not accepted within 64 cycles", b);
      end
   endtask

   task automatic start_load();
      wr_q.delete();
      hs_cnt    = 0;
      done_cnt  = 0;
      done_nowe = 0;
      stalls    = 0;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic run_load(input logic [15:0] len, input int nsend, input logic [15:0] w [16],
                           input int gap, input bit noise, input bit exp_err, input int exp_wl);
      start_load();
      check("busy_after_start", busy, 1);
      check("hold_after_start", hold_core, 1);
      check("error_cleared", error, 0);
      send_byte(len[15:8], gap, noise);
      send_byte(len[7:0], gap, noise);
      for (int i = 0; i < nsend; i++) begin
         send_byte(w[i][15:8], gap, noise);
         send_byte(w[i][7:0], gap, noise);
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("error", error, 32'(exp_err));
      check("words_loaded", words_loaded, exp_wl);
      check("hold_core_end", hold_core, 32'(exp_err));
      check("busy_end", busy, 0);
      check("in_ready_end", in_ready, 0);
      check("done_pulses", done_cnt, exp_err ? 0 : 1);
      check("done_without_we", done_nowe, 0);
      check("stalls", stalls, 0);
      check("write_count", wr_q.size(), exp_wl);
      for (int i = 0; i < wr_q.size() && i < exp_wl; i++)
         check("write_addr_data", wr_q[i], {4'h0, 12'(i), w[i]});
   endtask

   typedef struct packed {
      logic [15:0]      len;
      logic [7:0]       nsend;
      logic [0:3][15:0] w;
      logic [7:0]       gap;
      logic             exp_err;
      logic [7:0]       exp_wl;
   } vec_t;

   vec_t        vecs [6];
   logic [15:0] wa [16];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{len: 16'd2,      nsend: 8'd2, w: {16'h2012, 16'hC000, 16'h0, 16'h0}, gap: 8'd0, exp_err: 1'b0, exp_wl: 8'd2};
      vecs[1] = '{len: 16'd3,      nsend: 8'd3, w: {16'h1111, 16'hA222, 16'h3333, 16'h0}, gap: 8'd0, exp_err: 1'b0, exp_wl: 8'd3};
      vecs[2] = '{len: 16'd0,      nsend: 8'd0, w: {16'h0, 16'h0, 16'h0, 16'h0}, gap: 8'd0, exp_err: 1'b1, exp_wl: 8'd0};
      vecs[3] = '{len: 16'h1001,   nsend: 8'd0, w: {16'h0, 16'h0, 16'h0, 16'h0}, gap: 8'd1, exp_err: 1'b1, exp_wl: 8'd0};
      vecs[4] = '{len: 16'd2,      nsend: 8'd2, w: {16'h2012, 16'hF123, 16'h0, 16'h0}, gap: 8'd0, exp_err: 1'b1, exp_wl: 8'd1};
      vecs[5] = '{len: 16'd1,      nsend: 8'd1, w: {16'h0ABC, 16'h0, 16'h0, 16'h0}, gap: 8'd2, exp_err: 1'b0, exp_wl: 8'd1};

      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      #12;
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("idle");

      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < 16; i++) wa[i] = (i < 4) ? vecs[v].w[i] : 16'h0;
         run_load(vecs[v].len, int'(vecs[v].nsend), wa, int'(vecs[v].gap), 1'b0,
                  vecs[v].exp_err, int'(vecs[v].exp_wl));
      end

      // Asynchronous reset while the low byte of word 0 is pending.
      start_load();
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h02, 0, 1'b0);
      send_byte(8'h20, 0, 1'b0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_reset_vals("midload_reset");
      check("midload_no_write", wr_q.size(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 16; i++) wa[i] = (i < 4) ? vecs[0].w[i] : 16'h0;
      run_load(16'd2, 2, wa, 0, 1'b0, 1'b0, 2);

      // Randomized loads against the stream-level reference model.
      for (int r = 0; r < 24; r++) begin
         logic [15:0] len;
         int          n, nsend, wl;
         bit          err;
         if ($urandom_range(5, 0) == 0) begin
            len = ($urandom_range(1, 0) == 0) ? 16'd0 : 16'(4097 + $urandom_range(60000, 0));
            n   = 0;
         end else begin
            n   = $urandom_range(8, 1);
            len = 16'(n);
         end
         for (int i = 0; i < 16; i++) begin
            if ($urandom_range(7, 0) == 0) wa[i] = {4'hF, 12'($urandom)};
            else                           wa[i] = {4'($urandom_range(14, 0)), 12'($urandom)};
         end
         if (len == 16'd0 || len > 16'd4096) begin
            err = 1'b1; wl = 0; nsend = 0;
         end else begin
            err = 1'b0; wl = n; nsend = n;
            for (int i = n - 1; i >= 0; i--) begin
               if (wa[i][15:12] == 4'hF) begin
                  err = 1'b1; wl = i; nsend = i + 1;
               end
            end
         end
         run_load(len, nsend, wa, $urandom_range(3, 0), 1'b1, err, wl);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
